// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - memory bus between the copy engine and data memory

interface mem_copy_engine_if #(
  parameter int ADDR_W = 32
);
  logic              mem_we;
  logic              mem_byte_src;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  modport master (
    output mem_we,
    output mem_byte_src,
    output mem_a,
    output mem_wd,
    input  mem_rd
  );

  modport slave (
    input  mem_we,
    input  mem_byte_src,
    input  mem_a,
    input  mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block copy DMA engine, one element per READ/WRITE pair

module mem_copy_engine #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              byte_mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  count,
  mem_copy_engine_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [31:0]       data_q, data_d;
  logic              bm_q, bm_d;
  logic              err_q, err_d;

  logic              misaligned;
  logic [ADDR_W-1:0] stride;

  // Word transfers need both addresses on a 4-byte boundary; bytes go anywhere.
  assign misaligned = !byte_mode && ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00));
  assign stride     = bm_q ? ADDR_W'(1) : ADDR_W'(4);

  // State register; reset drops straight back to IDLE regardless of the phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: empty or misaligned requests finish without touching memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = S_DONE;
          end else if (misaligned) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: parameters latch only on an accepted start.
  always_comb begin
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    count_d   = count_q;
    data_d    = data_q;
    bm_d      = bm_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          rem_d     = len;
          bm_d      = byte_mode;
          count_d   = '0;
          err_d     = (len != '0) && misaligned;
        end
      end
      S_READ: begin
        // Only the low byte is meaningful in byte mode; keep the rest zero.
        data_d = bm_q ? {24'h0, mem.mem_rd[7:0]} : mem.mem_rd;
      end
      S_WRITE: begin
        src_ptr_d = src_ptr_q + stride;
        dst_ptr_d = dst_ptr_q + stride;
        rem_d     = rem_q - LEN_W'(1);
        count_d   = count_q + LEN_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      data_q    <= '0;
      bm_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      data_q    <= data_d;
      bm_q      <= bm_d;
      err_q     <= err_d;
    end
  end

  // Outputs decoded from state; the bus is parked at zero outside READ/WRITE.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_a        = '0;
    mem.mem_wd       = '0;
    mem.mem_byte_src = bm_q;
    err              = err_q;
    count            = count_q;
    case (state_q)
      S_READ: begin
        busy      = 1'b1;
        mem.mem_a = src_ptr_q;
      end
      S_WRITE: begin
        busy       = 1'b1;
        mem.mem_we = 1'b1;
        mem.mem_a  = dst_ptr_q;
        mem.mem_wd = data_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - self-checking bench for mem_copy_engine

module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        byte_mode;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] count;

  mem_copy_engine_if #(.ADDR_W(32)) mbus ();

  mem_copy_engine #(.LEN_W(16), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .byte_mode (byte_mode),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count),
    .mem       (mbus)
  );

  always #5 clk = ~clk;

  // 256-byte little-endian memory; upper address bits alias.
  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];

  // Combinational read port
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = mbus.mem_a[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    if (mbus.mem_byte_src) mbus.mem_rd = {24'h0, mem[a0]};
    else                   mbus.mem_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
  end

  int checks   = 0;
  int failures = 0;

  int busy_n, done_n, done_at, we_n, bus_bad;
  logic [31:0] rd_addrs[$];

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] n;
    logic        bm;
    int          pre;
    logic        exp_err;
    int          exp_busy;
    logic [15:0] exp_count;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Commit a DUT write if one is being presented this cycle.
  task automatic bus_write();
    logic [7:0] a;
    if (mbus.mem_we) begin
      we_n++;
      a = mbus.mem_a[7:0];
      mem[a] = mbus.mem_wd[7:0];
      if (!mbus.mem_byte_src) begin
        mem[8'(a + 8'd1)] = mbus.mem_wd[15:8];
        mem[8'(a + 8'd2)] = mbus.mem_wd[23:16];
        mem[8'(a + 8'd3)] = mbus.mem_wd[31:24];
      end
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 5) & 255);
  endtask

  task automatic preload(input int kind);
    case (kind)
      1: for (int i = 0; i < 16; i++) mem[i] = 8'(8'h11 * (i / 4 + 1));
      2: begin mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'hCC; end
      3: mem[0] = 8'h5A;
      default: ;
    endcase
  endtask

  // Reference: ascending element-by-element copy on the byte array.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input logic bm);
    logic [31:0] sa, da;
    logic [7:0]  tmp [4];
    int stride;
    exp_mem = mem;
    if (n == 0) return;
    if (!bm && (s[1:0] != 0 || d[1:0] != 0)) return;
    stride = bm ? 1 : 4;
    for (int i = 0; i < int'(n); i++) begin
      sa = s + 32'(i * stride);
      da = d + 32'(i * stride);
      if (bm) begin
        exp_mem[da[7:0]] = exp_mem[sa[7:0]];
      end else begin
        for (int b = 0; b < 4; b++) tmp[b] = exp_mem[8'(sa[7:0] + 8'(b))];
        for (int b = 0; b < 4; b++) exp_mem[8'(da[7:0] + 8'(b))] = tmp[b];
      end
    end
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input logic bm, input int repulse_k);
    busy_n = 0; done_n = 0; done_at = 0; we_n = 0; bus_bad = 0;
    rd_addrs.delete();
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; byte_mode = bm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 2 * int'(n) + 6; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      if (busy && mbus.mem_byte_src !== bm) bus_bad++;
      if (mbus.mem_we && bm && mbus.mem_wd[31:8] != 0) bus_bad++;
      if (!busy && (mbus.mem_we || mbus.mem_a != 0 || mbus.mem_wd != 0)) bus_bad++;
      if (busy && !mbus.mem_we) rd_addrs.push_back(mbus.mem_a);
      bus_write();
      if (k == repulse_k) begin
        start = 1'b1; src_addr = s + 32'h80; dst_addr = d + 32'h10;
        len = 16'(n + 3); byte_mode = ~bm;
      end
      if (k == repulse_k + 1) start = 1'b0;
      if (done_at != 0 && k == done_at + 1) break;
      @(negedge clk);
    end
  endtask

  task automatic check_xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input logic bm, input logic e_err,
                            input int e_busy, input logic [15:0] e_cnt);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) diffs++;
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(e_busy));
    check({tag, "_done_cycle"}, 64'(done_at), 64'(e_busy + 1));
    check({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    check({tag, "_err"}, 64'(err), 64'(e_err));
    check({tag, "_count"}, 64'(count), 64'(e_cnt));
    check({tag, "_writes"}, 64'(we_n), 64'(e_busy / 2));
    check({tag, "_bus_rules"}, 64'(bus_bad), 64'd0);
    check({tag, "_mem_diffs"}, 64'(diffs), 64'd0);
  endtask

  vec_t vecs [9];

  initial begin
    logic [31:0] s, d;
    logic [15:0] n;
    logic        bm, e_err;
    logic [7:0]  keep44;

    vecs[0] = '{32'h0,        32'h40, 16'd4, 1'b0, 1, 1'b0, 8,  16'd4};
    vecs[1] = '{32'h1,        32'h21, 16'd3, 1'b1, 2, 1'b0, 6,  16'd3};
    vecs[2] = '{32'h2,        32'h40, 16'd2, 1'b0, 0, 1'b1, 0,  16'd0};
    vecs[3] = '{32'h0,        32'h80, 16'd0, 1'b0, 0, 1'b0, 0,  16'd0};
    vecs[4] = '{32'hFFFFFFFC, 32'h60, 16'd2, 1'b0, 0, 1'b0, 4,  16'd2};
    vecs[5] = '{32'h0,        32'h1,  16'd3, 1'b1, 3, 1'b0, 6,  16'd3};
    vecs[6] = '{32'h0,        32'h41, 16'd1, 1'b0, 0, 1'b1, 0,  16'd0};
    vecs[7] = '{32'h3,        32'h82, 16'd5, 1'b1, 0, 1'b0, 10, 16'd5};
    vecs[8] = '{32'h2,        32'h40, 16'd0, 1'b0, 0, 1'b0, 0,  16'd0};

    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0; byte_mode = 1'b0;
    fill_pattern();
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_mem_we", 64'(mbus.mem_we), 64'd0);
    check("rst_byte_src", 64'(mbus.mem_byte_src), 64'd0);
    check("rst_mem_a", 64'(mbus.mem_a), 64'd0);
    check("rst_mem_wd", 64'(mbus.mem_wd), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int v = 0; v < 9; v++) begin
      fill_pattern();
      preload(vecs[v].pre);
      model_copy(vecs[v].src, vecs[v].dst, vecs[v].n, vecs[v].bm);
      run_xfer(vecs[v].src, vecs[v].dst, vecs[v].n, vecs[v].bm, -10);
      check_xfer($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].n, vecs[v].bm,
                 vecs[v].exp_err, vecs[v].exp_busy, vecs[v].exp_count);
      if (v == 0) check("word_dst_4C", {32'h0, mem[8'h4F], mem[8'h4E], mem[8'h4D], mem[8'h4C]}, 64'h44444444);
      if (v == 1) check("byte_dst_21_23", {40'h0, mem[8'h23], mem[8'h22], mem[8'h21]}, 64'hCCBBAA);
      if (v == 4) check("wrap_second_read", (rd_addrs.size() > 1) ? 64'(rd_addrs[1]) : 64'hDEAD, 64'h0);
      if (v == 5) check("overlap_replicate", {40'h0, mem[3], mem[2], mem[1]}, 64'h5A5A5A);
    end

    // Reset in the second WRITE: first element stays, the second is abandoned.
    fill_pattern();
    preload(1);
    keep44 = mem[8'h44];
    we_n = 0;
    @(negedge clk);
    src_addr = 32'h0; dst_addr = 32'h40; len = 16'd4; byte_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus_write();
    @(negedge clk);
    bus_write();
    @(negedge clk);
    bus_write();
    @(posedge clk);
    #2;
    check("rstmid_we_before", 64'(mbus.mem_we), 64'd1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_mem_we", 64'(mbus.mem_we), 64'd0);
    check("rstmid_mem_a", 64'(mbus.mem_a), 64'd0);
    check("rstmid_count", 64'(count), 64'd0);
    @(negedge clk);
    bus_write();
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_first_elem", {32'h0, mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 64'h11111111);
    check("rstmid_second_kept", 64'(mem[8'h44]), 64'(keep44));
    check("rstmid_writes", 64'(we_n), 64'd1);

    // Start re-pulsed with new parameters mid-transfer is ignored.
    fill_pattern();
    preload(1);
    model_copy(32'h0, 32'h40, 16'd4, 1'b0);
    run_xfer(32'h0, 32'h40, 16'd4, 1'b0, 3);
    check_xfer("restart", 32'h0, 32'h40, 16'd4, 1'b0, 1'b0, 8, 16'd4);

    // Randomized transfers against the reference model
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      bm = 1'($urandom);
      s = $urandom;
      d = $urandom;
      if (!bm && ($urandom_range(0, 3) != 0)) begin s[1:0] = 2'b00; d[1:0] = 2'b00; end
      n = 16'($urandom_range(0, 12));
      e_err = (n != 0) && !bm && (s[1:0] != 0 || d[1:0] != 0);
      model_copy(s, d, n, bm);
      run_xfer(s, d, n, bm, -10);
      check_xfer($sformatf("rnd%0d", r), s, d, n, bm, e_err,
                 (e_err || n == 0) ? 0 : 2 * int'(n), (e_err || n == 0) ? 16'd0 : n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
